// File: rtl/i2s_rx_frame_fifo.sv
// Frame FIFO behind the I2S receiver: buffers {left,right} stereo frames first-word-fall-through,
// hands them to the DSP stage over valid/ready, and drops frames when full while counting the drops.
module i2s_rx_frame_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             left_i,
  input  logic [WIDTH-1:0]             right_i,
  input  logic                         frame_valid_i,
  input  logic                         out_ready_i,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             left_o,
  output logic [WIDTH-1:0]             right_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         afull_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_cnt_o,
  input  logic                         clr_ovf_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

  // A pop frees the slot this cycle, so a full FIFO still accepts a frame alongside a pop.
  assign full = (count == CW'(DEPTH));
  assign pop  = out_valid_o & out_ready_i;
  assign push = frame_valid_i & (~full | pop);
  assign drop = frame_valid_i & full & ~pop;

  assign out_valid_o       = (count != '0);
  assign {left_o, right_o} = mem[rd_ptr];
  assign count_o           = count;
  assign afull_o           = (count >= CW'(AFULL_LVL));

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage is cleared on reset so the head word reads zero while empty;
      // this costs a reset on every flop, which is accepted for such a small array.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {left_i, right_i};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A drop in the same cycle as a clear wins, so the event is never lost.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (clr_ovf_i) begin
        drop_cnt_o <= 8'd1;
      end else if (drop_cnt_o != 8'hff) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end else if (clr_ovf_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

endmodule

// File: doc/i2s_rx_frame_fifo.md
Name: i2s_rx_frame_fifo

Overview:
- Sits directly downstream of the I2S receiver in the sclk domain.
- Captures each completed stereo frame (left + right word) when the receiver strobes a new packet, and buffers frames in a first-word-fall-through FIFO.
- Presents frames to the downstream DSP stage over a valid/ready handshake.
- Drops frames when full; reports drops via a sticky flag and a saturating counter.

Parameters:
- WIDTH, 16, bits per channel word.
- DEPTH, 8, frame capacity; power of two, at least 2.
- AFULL_LVL, 6, occupancy at or above which afull_o asserts; 1 ≤ AFULL_LVL ≤ DEPTH.

Ports:
- sclk  in  1  bit clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- left_i  in  WIDTH  received left word.
- right_i  in  WIDTH  received right word.
- frame_valid_i  in  1  one-cycle strobe: left_i/right_i hold a new complete frame.
- out_ready_i  in  1  downstream accepts the head frame this cycle.
- out_valid_o  out  1  head frame available.
- left_o  out  WIDTH  head frame left word.
- right_o  out  WIDTH  head frame right word.
- count_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- afull_o  out  1  count_o ≥ AFULL_LVL.
- overflow_o  out  1  sticky: at least one frame dropped.
- drop_cnt_o  out  8  saturating count of dropped frames.
- clr_ovf_i  in  1  synchronous clear of overflow_o and drop_cnt_o.

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, count=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0, afull_o=0. left_o/right_o read 0 while empty after reset (storage array zero-initialised on reset).
- Storage: DEPTH entries of {left,right}. Pointers are $clog2(DEPTH) bits, wrapping DEPTH-1→0. Occupancy is tracked by count, not pointer compare.
- Push: frame_valid_i=1 and (count<DEPTH or pop this cycle) → write {left_i,right_i} at wr_ptr, wr_ptr+1.
- Pop: out_valid_o=1 and out_ready_i=1 → rd_ptr+1.
- count next = count + push − pop.
- Output timing:
  - FWFT: left_o/right_o are combinational from mem[rd_ptr]; out_valid_o = (count≠0).
  - No same-cycle bypass: a push into an empty FIFO gives out_valid_o=1 on the next cycle (latency 1 cycle).
- Full + frame_valid_i with no pop: frame dropped, storage and pointers unchanged. Next cycle overflow_o=1 and drop_cnt_o+1, saturating at 255.
- Full + frame_valid_i + pop in the same cycle: push accepted, count stays DEPTH, no drop.
- Empty + out_ready_i: no effect; pointers unchanged.
- clr_ovf_i=1: overflow_o←0, drop_cnt_o←0. If a drop occurs in the same cycle, the drop wins: overflow_o←1, drop_cnt_o←1.
- Handshake: out_valid_o never deasserts without a pop. Head data is stable while out_valid_o=1 and out_ready_i=0, including when pushes occur.
- afull_o is combinational from count.
- Mid-operation reset: all frames discarded immediately; outputs return to reset values asynchronously.
- Upstream strobe is assumed single-cycle; a held-high frame_valid_i pushes once per cycle, each push a separate frame.

Test Plan:
1. Release reset; push one frame {dead,beef}, out_ready_i=0 → out_valid_o=1 one cycle later, left_o=16'hdead, right_o=16'hbeef, count_o=1; raise out_ready_i one cycle → count_o=0, out_valid_o=0.
2. Push 8 frames L=k, R=~k (k=0..7) with out_ready_i=0 → count_o=8, afull_o asserts when count_o reaches 6. Drain with out_ready_i=1 → frames emerge in order 0..7, then out_valid_o=0.
3. FIFO full; push 3 more frames without pop → overflow_o=1, drop_cnt_o=3, contents still 0..7. Pulse clr_ovf_i → both cleared.
4. FIFO full; simultaneous push L=16'h1234 and pop → count_o stays 8, no drop, 16'h1234 emerges last after draining.
5. Continuous pushes and pops with pointers wrapping over 20 frames, out_ready_i toggling every cycle → no loss, no duplication, order preserved, head stable while stalled.
6. Assert rst low mid-stream with count_o=5 → out_valid_o=0, count_o=0, drop_cnt_o=0 immediately; the first frame after release is delivered correctly.
